dcm_lock_seq: RTL and testbench
===============================

Name: dcm_lock_seq

Overview:
- Reset/lock sequencer placed directly upstream and downstream of the DCM_SP clock model.
- Drives the DCM RST input and consumes its LOCKED and STATUS outputs.
- Holds the downstream design in reset until lock has been stable for a qualified interval.
- Re-resets the DCM on loss of lock or a stopped CLKIN, and reports failure after too many unsuccessful attempts.

Parameters:
- RST_PULSE_CYCLES, 3: cycles dcm_rst is held high per attempt (minimum 1).
- LOCK_TIMEOUT, 1024: cycles to wait for lock before retrying (minimum 2).
- STABLE_CYCLES, 16: consecutive synchronized-lock cycles required before release (minimum 1).
- MAX_RETRIES, 4: failed attempts before entering FAIL; 0 means retry forever.
- CNT_W, 16: width of the shared cycle counter; must hold max(RST_PULSE_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).

Ports:
- clk, input, 1: free-running reference clock (the DCM CLKIN).
- resetb, input, 1: asynchronous active-low reset.
- enable, input, 1: sequencer run request, synchronous to clk.
- dcm_locked, input, 1: DCM LOCKED; asynchronous to clk, double-flop synchronized internally.
- dcm_status, input, 8: DCM STATUS; only bit 1 (CLKIN stopped) is used, double-flop synchronized.
- dcm_rst, output, 1: drives DCM RST, active high.
- sys_resetb, output, 1: active-low reset to the downstream logic.
- locked, output, 1: qualified lock indication.
- fail, output, 1: retry limit exhausted.
- retry_count, output, 8: failed attempts since the last start; saturates at 255.

Behaviour:
- Reset and clocking:
  - One clock (clk). Reset is asynchronous and active-low (resetb).
  - On resetb low: state=IDLE, dcm_rst=1, sys_resetb=0, locked=0, fail=0, retry_count=0, counter=0, sync flops=0.
- Outputs are registered and change on the same edge the state is entered. lock_s and stop_s are the 2nd-flop synchronizer outputs.
- States and transitions:
  - IDLE: dcm_rst=1. If enable=1: go to RESET, counter=0, retry_count=0.
  - RESET: dcm_rst=1 for exactly RST_PULSE_CYCLES cycles. Then go to WAIT_LOCK, counter=0.
  - WAIT_LOCK: dcm_rst=0, counter increments.
    - lock_s=1: go to STABLE, counter=0.
    - Otherwise, when counter reaches LOCK_TIMEOUT-1: retry_count+1, then FAIL if MAX_RETRIES!=0 and the new retry_count>=MAX_RETRIES, else RESET.
  - STABLE: dcm_rst=0, counter increments while lock_s=1.
    - lock_s=0: go back to WAIT_LOCK, counter=0. This is not counted as a retry.
    - counter==STABLE_CYCLES-1 with lock_s=1: go to RUN.
  - RUN: sys_resetb=1, locked=1.
    - lock_s=0 or stop_s=1: go to RESET, sys_resetb=0, locked=0, dcm_rst=1 on that edge, retry_count+1. Retry-limit check is identical to WAIT_LOCK.
  - FAIL: fail=1, dcm_rst=1, sys_resetb=0. Held until enable=0.
- enable=0 in any state: go to IDLE on the next edge, all outputs take their reset values except retry_count, which holds until the next start.
- Simultaneous events: enable=0 has priority over every other transition. In WAIT_LOCK, lock_s=1 on the timeout cycle wins, so no retry is counted.
- Latency from dcm_locked=1 first sampled at edge 0, in WAIT_LOCK: STABLE entered at edge 2; locked=1 and sys_resetb=1 at edge STABLE_CYCLES+2.
- Loss latency from dcm_locked=0 first sampled at edge 0, in RUN: sys_resetb=0 and dcm_rst=1 at edge 2.
- Glitch tolerance: a lock_s drop during STABLE restarts qualification. A dcm_locked pulse shorter than one clk period may be missed; this is acceptable.
- Asynchronous reset mid-operation returns to IDLE immediately. No dcm_rst glitch low is permitted: dcm_rst resets to 1.

Test Plan:
- Defaults, enable=1, dcm_locked rises 100 cycles after dcm_rst falls -> dcm_rst high exactly 3 cycles; locked and sys_resetb rise 18 edges after dcm_locked is first sampled high; retry_count=0.
- dcm_locked never asserts -> dcm_rst re-pulses every 1024+3 cycles. retry_count steps 1,2,3,4; fail=1 after the 4th timeout; dcm_rst=1 and sys_resetb=0 held. Drop enable -> IDLE with fail=0 and retry_count=4; re-enable -> retry_count=0.
- In STABLE, drop dcm_locked for 1 cycle at qualification count 10 -> no release. locked rises 16 stable cycles after lock returns; retry_count unchanged.
- In RUN, drop dcm_locked -> sys_resetb=0 and dcm_rst=1 two edges later; retry_count=1; relock -> RUN again.
- In RUN, assert dcm_status[1]=1 with dcm_locked=1 -> same response as loss of lock.
- enable=0 mid-WAIT_LOCK, then assert resetb=0 mid-RESET -> IDLE next edge or immediately respectively; dcm_rst=1 throughout with no low glitch.

Source files
------------

// File: rtl/dcm_lock_seq.sv
// Reset/lock sequencer around a DCM_SP: pulses DCM RST, qualifies LOCKED, then
// releases the downstream reset; re-resets the DCM on lock loss or a stopped CLKIN.
module dcm_lock_seq #(
    parameter int RST_PULSE_CYCLES = 3,
    parameter int LOCK_TIMEOUT     = 1024,
    parameter int STABLE_CYCLES    = 16,
    parameter int MAX_RETRIES      = 4,
    parameter int CNT_W            = 16
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       enable,
    input  logic       dcm_locked,
    input  logic [7:0] dcm_status,
    output logic       dcm_rst,
    output logic       sys_resetb,
    output logic       locked,
    output logic       fail,
    output logic [7:0] retry_count,
    output logic [2:0] state
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] RESET     = 3'd1;
    localparam logic [2:0] WAIT_LOCK = 3'd2;
    localparam logic [2:0] STABLE    = 3'd3;
    localparam logic [2:0] RUN       = 3'd4;
    localparam logic [2:0] FAIL      = 3'd5;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             lock_m, lock_s;
    logic             stop_m, stop_s;
    logic [7:0]       retry_inc;
    logic             retry_limit;

    // Only STATUS[1] (CLKIN stopped) matters; the other bits are deliberately ignored.
    logic unused_status;
    assign unused_status = ^{dcm_status[7:2], dcm_status[0]};

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
            stop_m <= 1'b0;
            stop_s <= 1'b0;
        end else begin
            lock_m <= dcm_locked;
            lock_s <= lock_m;
            stop_m <= dcm_status[1];
            stop_s <= stop_m;
        end
    end

    assign retry_inc   = (retry_count == 8'hFF) ? 8'hFF : retry_count + 8'd1;
    assign retry_limit = (MAX_RETRIES != 0) && (32'(retry_inc) >= MAX_RETRIES);

    // All outputs are registered alongside the state so they change on the entry edge.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state       <= IDLE;
            cnt         <= '0;
            dcm_rst     <= 1'b1;
            sys_resetb  <= 1'b0;
            locked      <= 1'b0;
            fail        <= 1'b0;
            retry_count <= 8'd0;
        end else if (!enable) begin
            state      <= IDLE;
            cnt        <= '0;
            dcm_rst    <= 1'b1;
            sys_resetb <= 1'b0;
            locked     <= 1'b0;
            fail       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state       <= RESET;
                    cnt         <= '0;
                    retry_count <= 8'd0;
                    dcm_rst     <= 1'b1;
                end
                RESET: begin
                    if (cnt == RST_LAST) begin
                        state   <= WAIT_LOCK;
                        cnt     <= '0;
                        dcm_rst <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    // Lock arriving on the timeout cycle wins over the retry.
                    if (lock_s) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        retry_count <= retry_inc;
                        cnt         <= '0;
                        dcm_rst     <= 1'b1;
                        if (retry_limit) begin
                            state <= FAIL;
                            fail  <= 1'b1;
                        end else begin
                            state <= RESET;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state      <= RUN;
                        cnt        <= '0;
                        sys_resetb <= 1'b1;
                        locked     <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (!lock_s || stop_s) begin
                        retry_count <= retry_inc;
                        cnt         <= '0;
                        dcm_rst     <= 1'b1;
                        sys_resetb  <= 1'b0;
                        locked      <= 1'b0;
                        if (retry_limit) begin
                            state <= FAIL;
                            fail  <= 1'b1;
                        end else begin
                            state <= RESET;
                        end
                    end
                end
                FAIL: begin
                    dcm_rst    <= 1'b1;
                    sys_resetb <= 1'b0;
                    locked     <= 1'b0;
                    fail       <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    cnt        <= '0;
                    dcm_rst    <= 1'b1;
                    sys_resetb <= 1'b0;
                    locked     <= 1'b0;
                    fail       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcm_lock_seq.sv
// Directed bench for dcm_lock_seq: a table of {inputs, cycles, expected outputs}
// records plus hand-written sequences for timeout, retry limit and async reset.
module tb_dcm_lock_seq;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RESET  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_STABLE = 3'd3;
    localparam logic [2:0] S_RUN    = 3'd4;
    localparam logic [2:0] S_FAIL   = 3'd5;

    logic       clk = 1'b0;
    logic       resetb;
    logic       enable;
    logic       dcm_locked;
    logic       stop_in;
    logic [7:0] dcm_status;
    logic       dcm_rst, sys_resetb, locked, fail;
    logic [7:0] retry_count;
    logic [2:0] state;

    int vec_count  = 0;
    int miss_count = 0;

    typedef struct {
        logic       en;
        logic       lk;
        logic       st;
        int         cyc;
        logic       rst;
        logic       sysb;
        logic       lck;
        logic       fl;
        logic [7:0] rc;
        logic [2:0] s;
        string      name;
    } vec_t;

    vec_t tbl[$];

    // Other STATUS bits are held high so only bit 1 may influence the DUT.
    assign dcm_status = {6'b111111, stop_in, 1'b1};

    dcm_lock_seq dut (
        .clk         (clk),
        .resetb      (resetb),
        .enable      (enable),
        .dcm_locked  (dcm_locked),
        .dcm_status  (dcm_status),
        .dcm_rst     (dcm_rst),
        .sys_resetb  (sys_resetb),
        .locked      (locked),
        .fail        (fail),
        .retry_count (retry_count),
        .state       (state)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic en, logic lk, logic st, int cyc, logic rst, logic sysb,
                                logic lck, logic fl, logic [7:0] rc, logic [2:0] s, string name);
        vec_t v;
        v.en = en; v.lk = lk; v.st = st; v.cyc = cyc;
        v.rst = rst; v.sysb = sysb; v.lck = lck; v.fl = fl; v.rc = rc; v.s = s;
        v.name = name;
        return v;
    endfunction

    task automatic compare(string name, logic rst, logic sysb, logic lck, logic fl,
                           logic [7:0] rc, logic [2:0] s);
        logic [14:0] got, exp;
        got = {dcm_rst, sys_resetb, locked, fail, retry_count, state};
        exp = {rst, sysb, lck, fl, rc, s};
        vec_count++;
        if (got !== exp) begin
            miss_count++;
            $display("FAIL %s: got rst=%b sysb=%b locked=%b fail=%b retry=%0d state=%0d, expected rst=%b sysb=%b locked=%b fail=%b retry=%0d state=%0d",
                     name, dcm_rst, sys_resetb, locked, fail, retry_count, state,
                     rst, sysb, lck, fl, rc, s);
        end
    endtask

    // Advance n clock edges and compare 1 ns after the last one.
    task automatic expect_after(string name, int n, logic rst, logic sysb, logic lck, logic fl,
                                logic [7:0] rc, logic [2:0] s);
        repeat (n) @(posedge clk);
        #1;
        compare(name, rst, sysb, lck, fl, rc, s);
    endtask

    initial begin
        resetb     = 1'b0;
        enable     = 1'b0;
        dcm_locked = 1'b0;
        stop_in    = 1'b0;

        // Normal lock, loss of lock, stopped CLKIN, STABLE glitch, enable drop.
        tbl.push_back(mk(0,0,0, 2, 1,0,0,0,0,S_IDLE,   "idle"));
        tbl.push_back(mk(1,0,0, 1, 1,0,0,0,0,S_RESET,  "start"));
        tbl.push_back(mk(1,0,0, 2, 1,0,0,0,0,S_RESET,  "pulse_third"));
        tbl.push_back(mk(1,0,0, 1, 0,0,0,0,0,S_WAIT,   "rst_fall"));
        tbl.push_back(mk(1,0,0,99, 0,0,0,0,0,S_WAIT,   "wait_100"));
        tbl.push_back(mk(1,1,0, 1, 0,0,0,0,0,S_WAIT,   "lock_e0"));
        tbl.push_back(mk(1,1,0, 1, 0,0,0,0,0,S_WAIT,   "lock_e1"));
        tbl.push_back(mk(1,1,0, 1, 0,0,0,0,0,S_STABLE, "lock_e2_stable"));
        tbl.push_back(mk(1,1,0,15, 0,0,0,0,0,S_STABLE, "lock_e17"));
        tbl.push_back(mk(1,1,0, 1, 0,1,1,0,0,S_RUN,    "lock_e18_run"));
        tbl.push_back(mk(1,0,0, 1, 0,1,1,0,0,S_RUN,    "loss_e0"));
        tbl.push_back(mk(1,0,0, 1, 0,1,1,0,0,S_RUN,    "loss_e1"));
        tbl.push_back(mk(1,0,0, 1, 1,0,0,0,1,S_RESET,  "loss_e2"));
        tbl.push_back(mk(1,1,0, 3, 0,0,0,0,1,S_WAIT,   "relock_wait"));
        tbl.push_back(mk(1,1,0, 1, 0,0,0,0,1,S_STABLE, "relock_stable"));
        tbl.push_back(mk(1,1,0,16, 0,1,1,0,1,S_RUN,    "relock_run"));
        tbl.push_back(mk(1,1,1, 2, 0,1,1,0,1,S_RUN,    "stop_e1"));
        tbl.push_back(mk(1,1,1, 1, 1,0,0,0,2,S_RESET,  "stop_e2"));
        tbl.push_back(mk(1,1,0, 3, 0,0,0,0,2,S_WAIT,   "stop_wait"));
        tbl.push_back(mk(1,1,0, 1, 0,0,0,0,2,S_STABLE, "stop_stable"));
        tbl.push_back(mk(1,1,0,10, 0,0,0,0,2,S_STABLE, "qual_10"));
        tbl.push_back(mk(1,0,0, 1, 0,0,0,0,2,S_STABLE, "glitch_a1"));
        tbl.push_back(mk(1,1,0, 1, 0,0,0,0,2,S_STABLE, "glitch_a2"));
        tbl.push_back(mk(1,1,0, 1, 0,0,0,0,2,S_WAIT,   "glitch_a3_wait"));
        tbl.push_back(mk(1,1,0, 1, 0,0,0,0,2,S_STABLE, "glitch_a4_stable"));
        tbl.push_back(mk(1,1,0, 2, 0,0,0,0,2,S_STABLE, "no_early_release"));
        tbl.push_back(mk(1,1,0,13, 0,0,0,0,2,S_STABLE, "requal_15"));
        tbl.push_back(mk(1,1,0, 1, 0,1,1,0,2,S_RUN,    "requal_run"));
        tbl.push_back(mk(1,0,0, 3, 1,0,0,0,3,S_RESET,  "loss2_reset"));
        tbl.push_back(mk(1,0,0, 3, 0,0,0,0,3,S_WAIT,   "loss2_wait"));
        tbl.push_back(mk(0,0,0, 1, 1,0,0,0,3,S_IDLE,   "disable_in_wait"));
        tbl.push_back(mk(1,0,0, 1, 1,0,0,0,0,S_RESET,  "restart_clears"));

        repeat (3) @(posedge clk);
        #1;
        compare("reset_state", 1, 0, 0, 0, 8'd0, S_IDLE);
        resetb = 1'b1;

        foreach (tbl[i]) begin
            enable     = tbl[i].en;
            dcm_locked = tbl[i].lk;
            stop_in    = tbl[i].st;
            expect_after(tbl[i].name, tbl[i].cyc, tbl[i].rst, tbl[i].sysb, tbl[i].lck,
                         tbl[i].fl, tbl[i].rc, tbl[i].s);
        end

        // Asynchronous reset in RESET: IDLE without waiting for a clock edge.
        expect_after("pre_async", 1, 1, 0, 0, 0, 8'd0, S_RESET);
        resetb = 1'b0;
        #2;
        compare("async_reset_now", 1, 0, 0, 0, 8'd0, S_IDLE);
        expect_after("async_reset_hold", 2, 1, 0, 0, 0, 8'd0, S_IDLE);
        resetb = 1'b1;

        // Lock never arrives: 1027-cycle retry period up to the limit.
        expect_after("to_start", 1, 1, 0, 0, 0, 8'd0, S_RESET);
        for (int k = 1; k <= 4; k++) begin
            expect_after($sformatf("to_wait_%0d", k), 1026, 0, 0, 0, 0, 8'(k - 1), S_WAIT);
            if (k < 4)
                expect_after($sformatf("to_retry_%0d", k), 1, 1, 0, 0, 0, 8'(k), S_RESET);
            else
                expect_after("to_fail", 1, 1, 0, 0, 1, 8'd4, S_FAIL);
        end
        expect_after("fail_hold", 20, 1, 0, 0, 1, 8'd4, S_FAIL);
        enable = 1'b0;
        expect_after("fail_disable", 1, 1, 0, 0, 0, 8'd4, S_IDLE);
        enable = 1'b1;
        expect_after("fail_restart", 1, 1, 0, 0, 0, 8'd0, S_RESET);

        // Lock becomes visible on exactly the timeout cycle: no retry counted.
        expect_after("tie_wait_w0", 3, 0, 0, 0, 0, 8'd0, S_WAIT);
        expect_after("tie_wait_w1021", 1021, 0, 0, 0, 0, 8'd0, S_WAIT);
        dcm_locked = 1'b1;
        expect_after("tie_wait_w1023", 2, 0, 0, 0, 0, 8'd0, S_WAIT);
        expect_after("tie_stable", 1, 0, 0, 0, 0, 8'd0, S_STABLE);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
